vec_cache_evict_serializer: RTL and testbench
=============================================

Name: vec_cache_evict_serializer

Overview:
- Sits between the data-SRAM evict read path and the downstream evict channel.
- Accepts one 1024-bit evict group per handshake (ram_to_evdb_pld_t), buffers up to DEPTH groups, and serializes each into BUS_WIDTH-bit beats (evict_to_ds_pld_t) with per-beat address and last.
- Issues a registered per-group completion pulse so the MSHR can release the evicting entry.

Parameters:
- DEPTH, 4, number of 1024-bit group entries buffered (power of 2, >=2).
- BEATS, 1024/BUS_WIDTH (=8), beats per group; derived, not overridden.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-high reset
- in_vld  input  1  evict group valid
- in_rdy  output  1  evict group accept
- in_pld  input  ram_to_evdb_pld_t  1024-bit data plus arb_out_req_t command
- out_vld  output  1  downstream beat valid
- out_rdy  input  1  downstream beat accept
- out_pld  output  evict_to_ds_pld_t  128-bit beat, addr, last, rob_entry_id, db_entry_id, txnid, sideband
- evict_done_vld  output  1  one-cycle pulse per fully sent group
- evict_done_rob_id  output  MSHR_ENTRY_IDX_WIDTH  rob_entry_id of the completed group
- count  output  $clog2(DEPTH)+1  occupied entries (debug/perf)

Behaviour:
- Storage: circular buffer of DEPTH entries, each holding 1024-bit data plus arb_out_req_t. Write pointer wptr, read pointer rptr, occupancy count, beat counter beat (3 bits).
- Reset (async, rst=1): wptr=rptr=0, count=0, beat=0, out_vld=0, evict_done_vld=0, evict_done_rob_id=0. in_rdy=1 as soon as rst deasserts. Storage contents are not reset.
- Push: in_vld && in_rdy. The entry is written at wptr on the clock edge, and wptr increments (mod DEPTH).
  - in_rdy = (count < DEPTH), derived from registered count only.
  - No push when full, even if a pop occurs in the same cycle.
- Output:
  - out_vld = (count != 0). The first beat of a pushed group is visible the cycle after the push (latency 1); no bypass.
  - out_pld.data = head data[beat*128 +: 128], beat 0 = bits [127:0].
  - out_pld.addr.tag = head tag; addr.index = head index; addr.offset = {head offset[8:7], beat[2:0], 4'b0000}.
  - out_pld.last = (beat == BEATS-1).
  - rob_entry_id, db_entry_id, txnid and sideband are copied from the head command.
- Handshake rules:
  - While out_vld && !out_rdy, out_pld holds stable.
  - out_vld never drops without a handshake, except on reset.
- Beat advance: on out_vld && out_rdy:
  - If beat != BEATS-1: beat increments.
  - Else: beat -> 0, rptr increments (mod DEPTH), count decrements.
  - The following cycle, evict_done_vld=1 and evict_done_rob_id = rob_entry_id of the popped entry. Otherwise evict_done_vld=0.
- Simultaneous push and final-beat pop: count is unchanged, both pointers advance.
  - The next head is the following entry; if the buffer held one entry, the newly pushed group becomes head with beat=0 on the next cycle.
- Pointer wrap: wptr and rptr wrap DEPTH-1 -> 0. Full/empty are decided from count, never from pointer equality.
- Back-to-back groups: beat 7 of group N and beat 0 of group N+1 go out on consecutive cycles with no bubble.
- Reset mid-group: all state clears, and any partially sent group is dropped with no evict_done. Upstream must re-issue.
- Assertions:
  - No in_vld && in_rdy when count == DEPTH.
  - out_pld stable under backpressure.
  - count <= DEPTH.

Decomposition:
- Shared package (vector_cache_pkg): reuse ram_to_evdb_pld_t, evict_to_ds_pld_t, arb_out_req_t, addr_t, BUS_WIDTH, MSHR_ENTRY_IDX_WIDTH.
- Add EVICT_BEATS = 1024/BUS_WIDTH to the package.
- One sub-module is natural: vec_cache_evict_buf, a DEPTH-entry circular buffer with pointers and count. The beat counter, slicing and done logic stay in the top.

Test Plan:
- Single group: push data with 128-bit word k = 128'hk repeated, tag=43'h1234, index=10'h3A, offset=9'h180, rob_entry_id=5, out_rdy=1 -> the cycle after push, 8 consecutive beats with data words 0..7 and offsets 9'h180,9'h190,...,9'h1F0; last only on beat 7; evict_done_vld pulses one cycle after beat 7 with rob_id=5.
- Backpressure: toggle out_rdy 1,0,0,1 repeatedly -> out_pld stable on every stalled cycle, exactly 8 beats delivered, no loss or duplication.
- Full: out_rdy=0, push 5 groups with DEPTH=4 -> in_rdy=0 after the 4th push and count=4; release out_rdy -> the 5th group is accepted only after group 0's beat 7 handshakes.
- Simultaneous push and pop: count=1 and the head is on beat 7; push in the same cycle as the beat-7 handshake -> count stays 1, and beat 0 of the new group appears the next cycle with no bubble.
- Wrap: push and drain 10 groups with rob_ids 0..9 under random out_rdy -> evict_done order is 0..9, and all beats carry the correct ids across pointer wrap.
- Reset mid-group: assert rst after beat 3 of a group -> out_vld=0, count=0, evict_done_vld=0 immediately; no stale beat after rst deasserts.

Source files
------------

// File: rtl/vector_cache_pkg.sv
// Shared vector-cache types: address, arbiter command, evict group and evict beat payloads.
// Latency: n/a (types, parameters and constants only).
// Backpressure: n/a.
package vector_cache_pkg;

  localparam int BUS_WIDTH            = 128;
  localparam int GROUP_WIDTH          = 1024;
  localparam int EVICT_BEATS          = GROUP_WIDTH / BUS_WIDTH;
  localparam int EVICT_BEAT_WIDTH     = $clog2(EVICT_BEATS);
  localparam int MSHR_ENTRY_IDX_WIDTH = 5;
  localparam int DB_ENTRY_IDX_WIDTH   = 4;
  localparam int TXNID_WIDTH          = 8;
  localparam int SIDEBAND_WIDTH       = 8;
  localparam int TAG_WIDTH            = 43;
  localparam int INDEX_WIDTH          = 10;
  localparam int OFFSET_WIDTH         = 9;
  // Byte offset bits covered by one bus beat (16 bytes per 128-bit beat).
  localparam int BEAT_BYTE_BITS       = $clog2(BUS_WIDTH / 8);
  // Offset bits that select bytes inside one 1024-bit group; the rest pick the group.
  localparam logic [OFFSET_WIDTH-1:0] GROUP_BYTE_MASK =
    OFFSET_WIDTH'((1 << (EVICT_BEAT_WIDTH + BEAT_BYTE_BITS)) - 1);

  typedef struct packed {
    logic [TAG_WIDTH-1:0]    tag;
    logic [INDEX_WIDTH-1:0]  index;
    logic [OFFSET_WIDTH-1:0] offset;
  } addr_t;

  typedef struct packed {
    addr_t                           addr;
    logic [MSHR_ENTRY_IDX_WIDTH-1:0] rob_entry_id;
    logic [DB_ENTRY_IDX_WIDTH-1:0]   db_entry_id;
    logic [TXNID_WIDTH-1:0]          txnid;
    logic [SIDEBAND_WIDTH-1:0]       sideband;
  } arb_out_req_t;

  typedef struct packed {
    logic [GROUP_WIDTH-1:0] data;
    arb_out_req_t           cmd;
  } ram_to_evdb_pld_t;

  typedef struct packed {
    logic [BUS_WIDTH-1:0]            data;
    addr_t                           addr;
    logic                            last;
    logic [MSHR_ENTRY_IDX_WIDTH-1:0] rob_entry_id;
    logic [DB_ENTRY_IDX_WIDTH-1:0]   db_entry_id;
    logic [TXNID_WIDTH-1:0]          txnid;
    logic [SIDEBAND_WIDTH-1:0]       sideband;
  } evict_to_ds_pld_t;

  // Byte offset of a beat: keep the group-select bits, replace the in-group bits with beat*16.
  function automatic logic [OFFSET_WIDTH-1:0] beat_offset(
    input logic [OFFSET_WIDTH-1:0]     group_offset,
    input logic [EVICT_BEAT_WIDTH-1:0] beat
  );
    return (group_offset & ~GROUP_BYTE_MASK) | (OFFSET_WIDTH'(beat) << BEAT_BYTE_BITS);
  endfunction

endpackage

// File: rtl/vec_cache_evict_buf.sv
// Circular buffer of DEPTH evict groups with write/read pointers and occupancy count.
// Latency: a pushed entry becomes head on the cycle after the push edge (no bypass).
// Backpressure: caller only pushes when count < DEPTH; full/empty come from count alone.
module vec_cache_evict_buf
  import vector_cache_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  ram_to_evdb_pld_t         push_pld,
  input  logic                     pop,
  output ram_to_evdb_pld_t         head_pld,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  ram_to_evdb_pld_t  mem [DEPTH];
  logic [PTR_W-1:0]  wptr;
  logic [PTR_W-1:0]  rptr;

  // Storage write; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr] <= push_pld;
    end
  end

  // Pointer and occupancy update; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + PTR_W'(1);
      if (pop)  rptr <= rptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  assign head_pld = mem[rptr];

endmodule

// File: rtl/vec_cache_evict_serializer.sv
// Buffers 1024-bit evict groups and emits each as 8 x 128-bit beats with per-beat addr/last.
// Latency: first beat one cycle after the push; done pulse one cycle after the last-beat handshake.
// Backpressure: out_pld holds while out_rdy is low; in_rdy drops when DEPTH groups are buffered.
module vec_cache_evict_serializer
  import vector_cache_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_vld,
  output logic                            in_rdy,
  input  ram_to_evdb_pld_t                in_pld,
  output logic                            out_vld,
  input  logic                            out_rdy,
  output evict_to_ds_pld_t                out_pld,
  output logic                            evict_done_vld,
  output logic [MSHR_ENTRY_IDX_WIDTH-1:0] evict_done_rob_id,
  output logic [$clog2(DEPTH):0]          count
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  ram_to_evdb_pld_t              head;
  logic [EVICT_BEAT_WIDTH-1:0]   beat;
  logic                          push;
  logic                          pop;
  logic                          last_beat;
  logic                          beat_hs;

  assign in_rdy    = (count < CNT_W'(DEPTH));
  assign push      = in_vld && in_rdy;
  assign out_vld   = (count != '0);
  assign last_beat = (beat == EVICT_BEAT_WIDTH'(EVICT_BEATS - 1));
  assign beat_hs   = out_vld && out_rdy;
  assign pop       = beat_hs && last_beat;

  vec_cache_evict_buf #(
    .DEPTH (DEPTH)
  ) u_buf (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_pld (in_pld),
    .pop      (pop),
    .head_pld (head),
    .count    (count)
  );

  // Slice the head group into the current beat; every field depends only on registered state.
  always_comb begin
    out_pld              = '0;
    out_pld.data         = head.data[beat*BUS_WIDTH +: BUS_WIDTH];
    out_pld.addr.tag     = head.cmd.addr.tag;
    out_pld.addr.index   = head.cmd.addr.index;
    out_pld.addr.offset  = beat_offset(head.cmd.addr.offset, beat);
    out_pld.last         = last_beat;
    out_pld.rob_entry_id = head.cmd.rob_entry_id;
    out_pld.db_entry_id  = head.cmd.db_entry_id;
    out_pld.txnid        = head.cmd.txnid;
    out_pld.sideband     = head.cmd.sideband;
  end

  // Beat counter advances per accepted beat and restarts at 0 for the next group.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat <= '0;
    end else if (beat_hs) begin
      beat <= last_beat ? '0 : beat + EVICT_BEAT_WIDTH'(1);
    end
  end

  // Registered completion pulse so the MSHR can release the evicting entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      evict_done_vld    <= 1'b0;
      evict_done_rob_id <= '0;
    end else begin
      evict_done_vld <= pop;
      if (pop) evict_done_rob_id <= head.cmd.rob_entry_id;
    end
  end

  a_no_push_when_full: assert property (@(posedge clk) disable iff (rst)
    !(in_vld && in_rdy && count == CNT_W'(DEPTH)));

  a_out_stable: assert property (@(posedge clk) disable iff (rst)
    (out_vld && !out_rdy) |=> (out_vld && $stable(out_pld)));

  a_count_bound: assert property (@(posedge clk) disable iff (rst)
    count <= CNT_W'(DEPTH));

endmodule

// File: tb/tb_vec_cache_evict_serializer.sv
// Randomized bench for the evict serializer against a queue-based group/beat model.
// Latency: n/a.
// Backpressure: out_rdy pattern selected per scenario (always, 1-0-0-1, random, never).
module tb_vec_cache_evict_serializer;
  import vector_cache_pkg::*;

  localparam int DEPTH = 4;

  logic                            clk = 1'b0;
  logic                            rst = 1'b1;
  logic                            in_vld = 1'b0;
  logic                            in_rdy;
  ram_to_evdb_pld_t                in_pld = '0;
  logic                            out_vld;
  logic                            out_rdy = 1'b0;
  evict_to_ds_pld_t                out_pld;
  logic                            evict_done_vld;
  logic [MSHR_ENTRY_IDX_WIDTH-1:0] evict_done_rob_id;
  logic [$clog2(DEPTH):0]          count;

  int errors = 0;
  int checks = 0;
  int rdy_mode = 0;
  int cyc = 0;

  ram_to_evdb_pld_t                sent_q[$];
  evict_to_ds_pld_t                rcv_q[$];
  logic [MSHR_ENTRY_IDX_WIDTH-1:0] done_q[$];

  vec_cache_evict_serializer #(.DEPTH(DEPTH)) dut (
    .clk               (clk),
    .rst               (rst),
    .in_vld            (in_vld),
    .in_rdy            (in_rdy),
    .in_pld            (in_pld),
    .out_vld           (out_vld),
    .out_rdy           (out_rdy),
    .out_pld           (out_pld),
    .evict_done_vld    (evict_done_vld),
    .evict_done_rob_id (evict_done_rob_id),
    .count             (count)
  );

  initial forever #5 clk = ~clk;

  // Downstream ready generator: 0 always, 1 pattern 1-0-0-1, 2 random, other never.
  initial forever begin
    @(posedge clk);
    #1;
    cyc++;
    case (rdy_mode)
      0:       out_rdy = 1'b1;
      1:       out_rdy = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      2:       out_rdy = 1'($urandom_range(0, 1));
      default: out_rdy = 1'b0;
    endcase
  end

  // Record beats that actually handshake at the next edge, and every done pulse.
  initial begin
    logic             pend;
    evict_to_ds_pld_t pend_pld;
    forever begin
      @(negedge clk);
      pend     = out_vld && out_rdy;
      pend_pld = out_pld;
      if (evict_done_vld) done_q.push_back(evict_done_rob_id);
      @(posedge clk);
      if (pend && !rst) rcv_q.push_back(pend_pld);
    end
  end

  // Model: beat k of a group is the k-th 128-bit slice, at group byte base + 16*k.
  function automatic evict_to_ds_pld_t exp_beat(input ram_to_evdb_pld_t g, input int k);
    evict_to_ds_pld_t p;
    logic [GROUP_WIDTH-1:0] sh;
    int base;
    sh   = g.data >> (k * BUS_WIDTH);
    base = (int'(g.cmd.addr.offset) / 128) * 128;
    p.data         = sh[BUS_WIDTH-1:0];
    p.addr.tag     = g.cmd.addr.tag;
    p.addr.index   = g.cmd.addr.index;
    p.addr.offset  = OFFSET_WIDTH'(base + 16 * k);
    p.last         = (k == EVICT_BEATS - 1);
    p.rob_entry_id = g.cmd.rob_entry_id;
    p.db_entry_id  = g.cmd.db_entry_id;
    p.txnid        = g.cmd.txnid;
    p.sideband     = g.cmd.sideband;
    return p;
  endfunction

  function automatic ram_to_evdb_pld_t rand_group(input int rob);
    ram_to_evdb_pld_t g;
    logic [63:0] t;
    for (int i = 0; i < GROUP_WIDTH / 32; i++) g.data[i*32 +: 32] = $urandom();
    t = {$urandom(), $urandom()};
    g.cmd.addr.tag     = t[TAG_WIDTH-1:0];
    g.cmd.addr.index   = INDEX_WIDTH'($urandom());
    g.cmd.addr.offset  = OFFSET_WIDTH'($urandom());
    g.cmd.rob_entry_id = MSHR_ENTRY_IDX_WIDTH'(rob);
    g.cmd.db_entry_id  = DB_ENTRY_IDX_WIDTH'($urandom());
    g.cmd.txnid        = TXNID_WIDTH'($urandom());
    g.cmd.sideband     = SIDEBAND_WIDTH'($urandom());
    return g;
  endfunction

  task automatic apply_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    in_vld = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    sent_q.delete();
    rcv_q.delete();
    done_q.delete();
  endtask

  // Offer a group and hold it until accepted; returns at edge+1 after the push edge.
  task automatic push_group(input ram_to_evdb_pld_t g);
    int n = 0;
    in_pld = g;
    in_vld = 1'b1;
    do begin
      @(negedge clk); #2;
      n++;
    end while (!in_rdy && n < 300);
    checks++;
    if (!in_rdy) begin
      errors++;
      $display("FAIL push_accept: in_rdy=%0b after %0d cycles, required 1", in_rdy, n);
      in_vld = 1'b0;
      return;
    end
    @(posedge clk);
    sent_q.push_back(g);
    #1 in_vld = 1'b0;
  endtask

  task automatic wait_done(input int n, output bit ok);
    int c = 0;
    while (done_q.size() < n && c < 3000) begin
      @(posedge clk); #1;
      c++;
    end
    ok = (done_q.size() >= n);
  endtask

  task automatic test_reset();
    #3;
    checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL reset_out_vld: got %0b want 0", out_vld); end
    checks++; if (count !== '0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
    checks++; if (evict_done_vld !== 1'b0) begin errors++; $display("FAIL reset_done_vld: got %0b want 0", evict_done_vld); end
    checks++; if (evict_done_rob_id !== '0) begin errors++; $display("FAIL reset_done_rob: got %0d want 0", evict_done_rob_id); end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk); #2;
    checks++; if (in_rdy !== 1'b1) begin errors++; $display("FAIL reset_in_rdy: got %0b want 1", in_rdy); end
    checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL reset_idle_out_vld: got %0b want 0", out_vld); end
  endtask

  task automatic test_single();
    ram_to_evdb_pld_t g;
    logic [3:0] nib;
    rdy_mode = 0;
    apply_reset();
    g = rand_group(5);
    for (int k = 0; k < EVICT_BEATS; k++) begin
      nib = 4'(k);
      g.data[k*BUS_WIDTH +: BUS_WIDTH] = {32{nib}};
    end
    g.cmd.addr.tag    = 43'h1234;
    g.cmd.addr.index  = 10'h3A;
    g.cmd.addr.offset = 9'h180;
    push_group(g);
    for (int k = 0; k < EVICT_BEATS; k++) begin
      @(negedge clk); #2;
      nib = 4'(k);
      checks++; if (out_vld !== 1'b1) begin errors++; $display("FAIL single_vld beat%0d: got %0b want 1", k, out_vld); end
      checks++; if (out_pld.data !== {32{nib}}) begin errors++; $display("FAIL single_data beat%0d: got %h want %h", k, out_pld.data, {32{nib}}); end
      checks++; if (out_pld.addr.offset !== 9'h180 + 9'(16 * k)) begin errors++; $display("FAIL single_offset beat%0d: got %h want %h", k, out_pld.addr.offset, 9'h180 + 9'(16 * k)); end
      checks++; if (out_pld.last !== (k == 7)) begin errors++; $display("FAIL single_last beat%0d: got %0b want %0b", k, out_pld.last, (k == 7)); end
      checks++; if (out_pld.addr.tag !== 43'h1234 || out_pld.addr.index !== 10'h3A || out_pld.rob_entry_id !== 5'd5) begin
        errors++; $display("FAIL single_ids beat%0d: tag=%h idx=%h rob=%0d want 1234/3a/5", k, out_pld.addr.tag, out_pld.addr.index, out_pld.rob_entry_id);
      end
    end
    @(negedge clk); #2;
    checks++; if (evict_done_vld !== 1'b1 || evict_done_rob_id !== 5'd5) begin errors++; $display("FAIL single_done: vld=%0b rob=%0d want 1/5", evict_done_vld, evict_done_rob_id); end
    checks++; if (out_vld !== 1'b0 || count !== '0) begin errors++; $display("FAIL single_empty: vld=%0b count=%0d want 0/0", out_vld, count); end
    @(negedge clk); #2;
    checks++; if (evict_done_vld !== 1'b0) begin errors++; $display("FAIL single_done_pulse: vld=%0b want 0", evict_done_vld); end
  endtask

  task automatic test_backpressure();
    ram_to_evdb_pld_t g;
    evict_to_ds_pld_t prev_pld;
    logic prev_stall = 1'b0;
    int stalls = 0;
    rdy_mode = 1;
    apply_reset();
    g = rand_group(7);
    push_group(g);
    for (int c = 0; c < 100 && done_q.size() == 0; c++) begin
      @(negedge clk); #2;
      if (prev_stall) begin
        stalls++;
        checks++; if (out_vld !== 1'b1 || out_pld !== prev_pld) begin errors++; $display("FAIL bp_stable cyc%0d: vld=%0b pld=%h want held %h", c, out_vld, out_pld, prev_pld); end
      end
      prev_stall = out_vld && !out_rdy;
      prev_pld   = out_pld;
    end
    checks++; if (stalls == 0) begin errors++; $display("FAIL bp_stalls: got %0d stalled cycles want >0", stalls); end
    checks++; if (rcv_q.size() != EVICT_BEATS) begin errors++; $display("FAIL bp_beats: got %0d want %0d", rcv_q.size(), EVICT_BEATS); end
    for (int k = 0; k < EVICT_BEATS && k < rcv_q.size(); k++) begin
      checks++; if (rcv_q[k] !== exp_beat(g, k)) begin errors++; $display("FAIL bp_beat%0d: got %h want %h", k, rcv_q[k], exp_beat(g, k)); end
    end
  endtask

  task automatic test_full();
    ram_to_evdb_pld_t g4;
    bit ok;
    int n = 0;
    rdy_mode = 3;
    apply_reset();
    for (int i = 0; i < DEPTH; i++) push_group(rand_group(i));
    @(negedge clk); #2;
    checks++; if (in_rdy !== 1'b0 || count !== 3'(DEPTH)) begin errors++; $display("FAIL full_state: in_rdy=%0b count=%0d want 0/%0d", in_rdy, count, DEPTH); end
    g4 = rand_group(4);
    in_pld = g4;
    in_vld = 1'b1;
    rdy_mode = 0;
    while (!in_rdy && n < 60) begin
      @(negedge clk); #2;
      n++;
    end
    checks++; if (!in_rdy || rcv_q.size() != EVICT_BEATS) begin errors++; $display("FAIL full_accept_point: in_rdy=%0b beats_sent=%0d want 1/%0d", in_rdy, rcv_q.size(), EVICT_BEATS); end
    @(posedge clk);
    sent_q.push_back(g4);
    #1 in_vld = 1'b0;
    wait_done(5, ok);
    checks++; if (!ok) begin errors++; $display("FAIL full_drain: done=%0d want 5", done_q.size()); end
    for (int i = 0; i < 5 && i < done_q.size(); i++) begin
      checks++; if (done_q[i] !== 5'(i)) begin errors++; $display("FAIL full_done_order%0d: got %0d want %0d", i, done_q[i], i); end
    end
    checks++; if (rcv_q.size() != 5 * EVICT_BEATS) begin errors++; $display("FAIL full_beats: got %0d want %0d", rcv_q.size(), 5 * EVICT_BEATS); end
    for (int k = 0; k < rcv_q.size() && k < 5 * EVICT_BEATS; k++) begin
      checks++; if (rcv_q[k] !== exp_beat(sent_q[k / EVICT_BEATS], k % EVICT_BEATS)) begin errors++; $display("FAIL full_beat%0d: got %h want %h", k, rcv_q[k], exp_beat(sent_q[k / EVICT_BEATS], k % EVICT_BEATS)); end
    end
  endtask

  task automatic test_simul();
    ram_to_evdb_pld_t ga;
    ram_to_evdb_pld_t gb;
    bit ok;
    rdy_mode = 0;
    apply_reset();
    ga = rand_group(1);
    gb = rand_group(2);
    push_group(ga);
    repeat (7) @(posedge clk);
    #1;
    in_pld = gb;
    in_vld = 1'b1;
    @(negedge clk); #2;
    checks++; if (count !== 3'd1 || out_pld.last !== 1'b1 || in_rdy !== 1'b1 || out_pld.rob_entry_id !== 5'd1) begin
      errors++; $display("FAIL simul_pre: count=%0d last=%0b in_rdy=%0b rob=%0d want 1/1/1/1", count, out_pld.last, in_rdy, out_pld.rob_entry_id);
    end
    @(posedge clk);
    sent_q.push_back(gb);
    #1 in_vld = 1'b0;
    @(negedge clk); #2;
    checks++; if (count !== 3'd1 || out_vld !== 1'b1) begin errors++; $display("FAIL simul_count: count=%0d vld=%0b want 1/1", count, out_vld); end
    checks++; if (out_pld !== exp_beat(gb, 0)) begin errors++; $display("FAIL simul_next_head: got %h want %h", out_pld, exp_beat(gb, 0)); end
    checks++; if (evict_done_vld !== 1'b1 || evict_done_rob_id !== 5'd1) begin errors++; $display("FAIL simul_done: vld=%0b rob=%0d want 1/1", evict_done_vld, evict_done_rob_id); end
    wait_done(2, ok);
    checks++; if (!ok || rcv_q.size() != 2 * EVICT_BEATS) begin errors++; $display("FAIL simul_drain: done=%0d beats=%0d want 2/%0d", done_q.size(), rcv_q.size(), 2 * EVICT_BEATS); end
    for (int k = 0; k < rcv_q.size() && k < 2 * EVICT_BEATS; k++) begin
      checks++; if (rcv_q[k] !== exp_beat(sent_q[k / EVICT_BEATS], k % EVICT_BEATS)) begin errors++; $display("FAIL simul_beat%0d: got %h want %h", k, rcv_q[k], exp_beat(sent_q[k / EVICT_BEATS], k % EVICT_BEATS)); end
    end
  endtask

  task automatic test_wrap();
    bit ok;
    rdy_mode = 2;
    apply_reset();
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
          push_group(rand_group(i));
        end
      end
      begin
        wait_done(10, ok);
      end
    join
    checks++; if (!ok) begin errors++; $display("FAIL wrap_drain: done=%0d want 10", done_q.size()); end
    for (int i = 0; i < 10 && i < done_q.size(); i++) begin
      checks++; if (done_q[i] !== 5'(i)) begin errors++; $display("FAIL wrap_done_order%0d: got %0d want %0d", i, done_q[i], i); end
    end
    checks++; if (rcv_q.size() != 10 * EVICT_BEATS || sent_q.size() != 10) begin errors++; $display("FAIL wrap_beats: got %0d beats %0d groups want 80/10", rcv_q.size(), sent_q.size()); end
    for (int k = 0; k < rcv_q.size() && k / EVICT_BEATS < sent_q.size(); k++) begin
      checks++; if (rcv_q[k] !== exp_beat(sent_q[k / EVICT_BEATS], k % EVICT_BEATS)) begin errors++; $display("FAIL wrap_beat%0d: got %h want %h", k, rcv_q[k], exp_beat(sent_q[k / EVICT_BEATS], k % EVICT_BEATS)); end
    end
  endtask

  task automatic test_reset_mid();
    ram_to_evdb_pld_t g;
    int stale = 0;
    rdy_mode = 0;
    apply_reset();
    g = rand_group(9);
    push_group(g);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    checks++; if (out_vld !== 1'b0 || count !== '0 || evict_done_vld !== 1'b0) begin
      errors++; $display("FAIL mid_reset_clear: vld=%0b count=%0d done=%0b want 0/0/0", out_vld, count, evict_done_vld);
    end
    checks++; if (rcv_q.size() != 4) begin errors++; $display("FAIL mid_reset_partial: beats=%0d want 4", rcv_q.size()); end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk); #2;
      if (out_vld !== 1'b0 || evict_done_vld !== 1'b0) stale++;
    end
    checks++; if (stale != 0) begin errors++; $display("FAIL mid_reset_stale: %0d stale cycles want 0", stale); end
    checks++; if (done_q.size() != 0) begin errors++; $display("FAIL mid_reset_done: got %0d done pulses want 0", done_q.size()); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_full();
    test_simul();
    test_wrap();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
